// File: rtl/fp32_mul_service.sv
// Single-precision floating-point multiplier behind a start/busy handshake.
// Uses a 24-cycle shift-add mantissa multiplier with a fixed 26-cycle busy window.
module fp32_mul_service #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic                 start,
    output logic [DATA_SIZE-1:0] result,
    output logic                 busy
);

    localparam int MUL_CYCLES = 24;
    localparam int LATENCY    = 26;

    generate
        if (DATA_SIZE != 32) begin : gBadSize
            $error("fp32_mul_service supports DATA_SIZE = 32 only");
        end
        if (LATENCY != MUL_CYCLES + 2) begin : gBadLatency
            $error("fp32_mul_service latency does not match its state sequence");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, UNPACK, MUL, ROUND} state_t;

    state_t              state_q, state_d;
    logic [31:0]         opA_q, opA_d, opB_q, opB_d;
    logic                sign_q, sign_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [47:0]         mcand_q, mcand_d;
    logic [23:0]         mplier_q, mplier_d;
    logic [47:0]         acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                special_q, special_d;
    logic [31:0]         specialVal_q, specialVal_d;
    logic [31:0]         result_q, result_d;

    logic [7:0]          expA, expB;
    logic                zeroA, zeroB, infA, infB, nanA, nanB;
    logic [23:0]         mantPre;
    logic                guardBit, stickyBit, roundUp;
    logic [24:0]         mantInc;
    logic signed [9:0]   expNorm, expFinal;
    logic [22:0]         fracOut;
    logic [31:0]         arithResult;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            opA_q        <= '0;
            opB_q        <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            special_q    <= 1'b0;
            specialVal_q <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            special_q    <= special_d;
            specialVal_q <= specialVal_d;
            result_q     <= result_d;
        end
    end

    // Operand classification; denormals share the zero class (flush-to-zero).
    always_comb begin
        expA  = opA_q[30:23];
        expB  = opB_q[30:23];
        zeroA = (expA == 8'h00);
        zeroB = (expB == 8'h00);
        infA  = (expA == 8'hFF) && (opA_q[22:0] == 23'd0);
        infB  = (expB == 8'hFF) && (opB_q[22:0] == 23'd0);
        nanA  = (expA == 8'hFF) && (opA_q[22:0] != 23'd0);
        nanB  = (expB == 8'hFF) && (opB_q[22:0] != 23'd0);
    end

    always_comb begin
        if (acc_q[47]) begin
            mantPre   = acc_q[47:24];
            guardBit  = acc_q[23];
            stickyBit = |acc_q[22:0];
            expNorm   = exp_q + 10'sd1;
        end else begin
            mantPre   = acc_q[46:23];
            guardBit  = acc_q[22];
            stickyBit = |acc_q[21:0];
            expNorm   = exp_q;
        end
        roundUp = guardBit & (stickyBit | mantPre[0]);
        mantInc = {1'b0, mantPre} + {24'd0, roundUp};
        if (mantInc[24]) begin
            fracOut  = 23'd0;
            expFinal = expNorm + 10'sd1;
        end else begin
            fracOut  = mantInc[22:0];
            expFinal = expNorm;
        end
        if (expFinal >= 10'sd255) begin
            arithResult = {sign_q, 8'hFF, 23'd0};
        end else if (expFinal <= 10'sd0) begin
            arithResult = {sign_q, 31'd0};
        end else begin
            arithResult = {sign_q, expFinal[7:0], fracOut};
        end
    end

    always_comb begin
        state_d      = state_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        special_d    = special_q;
        specialVal_d = specialVal_q;
        result_d     = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d   = opA_q[31] ^ opB_q[31];
                exp_d    = $signed({2'b00, expA}) + $signed({2'b00, expB}) - 10'sd127;
                mcand_d  = {24'd0, 1'b1, opA_q[22:0]};
                mplier_d = {1'b1, opB_q[22:0]};
                acc_d    = '0;
                cnt_d    = '0;
                special_d    = 1'b1;
                if (nanA || nanB || (infA && zeroB) || (infB && zeroA)) begin
                    specialVal_d = 32'h7FC0_0000;
                end else if (infA || infB) begin
                    specialVal_d = {opA_q[31] ^ opB_q[31], 8'hFF, 23'd0};
                end else if (zeroA || zeroB) begin
                    specialVal_d = {opA_q[31] ^ opB_q[31], 31'd0};
                end else begin
                    special_d    = 1'b0;
                    specialVal_d = '0;
                end
                state_d = MUL;
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d = special_q ? specialVal_q : arithResult;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign result = result_q;

endmodule

// File: doc/fp32_mul_service.md
Name: fp32_mul_service

Overview:
- Responder (service) end of the calculator start/busy handshake: accepts operands a, b on start, computes the IEEE-754 single-precision product a*b, and returns result when busy drops.
- Iterative shift-add mantissa multiplier with fixed latency; sits behind any client that drives a, b and start and waits on busy.
- Provides the multiply slot of the float-point ALU without using DSP primitives.

Parameters:
DATA_SIZE, 32, operand/result width; only 32 is supported. Any other value is a static elaboration error.
LATENCY, 26, busy-high cycle count. This is derived, not user-settable; it is exposed for benches only.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
a  input  DATA_SIZE  operand A, fp32, sampled on accepted start
b  input  DATA_SIZE  operand B, fp32, sampled on accepted start
start  input  1  request pulse; accepted only when busy=0
result  output  DATA_SIZE  fp32 product, registered, held until next completion
busy  output  1  high while a computation is in flight

Behaviour:
- Reset (async, active-high): busy=0, result=0x00000000, FSM=IDLE, all datapath registers cleared.
- Reset mid-operation: the in-flight job is discarded and no result is written.
- Handshake:
  - start is accepted on an edge where start=1 and busy=0. a and b are captured on that edge.
  - start while busy=1 is ignored. There is no queueing and operand capture is unaffected.
  - busy=1 from the edge after acceptance for exactly 26 cycles.
  - On the edge where busy falls, result takes the new value in the same cycle.
  - start held high continuously begins a new job on the first edge with busy=0. Back-to-back throughput is 1 job per 27 cycles.
  - result is stable whenever busy=0.
- FSM states:
  - IDLE: busy=0. On accepted start, go to UNPACK.
  - UNPACK, 1 cycle:
    - Split sign, exponent and mantissa, and insert the hidden bit.
    - Classify each operand as zero, denormal, inf, NaN or normal. Denormals are flushed to zero (FTZ on input).
    - Compute sign = sa^sb.
    - Compute exp = ea+eb-127 as a 10-bit signed value.
  - MUL, 24 cycles:
    - 48-bit accumulator. Each cycle: if the multiplier LSB=1, add the multiplicand at the current shift; shift the multiplier right.
    - Use a 5-bit iteration counter running 0..23. Exit to ROUND when the counter reaches 23.
  - ROUND, 1 cycle:
    - If p[47]=1, take mant=p[47:24] with guard p[23] and sticky |p[22:0], and exp+1. Otherwise take mant=p[46:23] with guard p[22] and sticky |p[21:0].
    - Round to nearest even: increment if guard & (sticky | mant[0]).
    - If the increment carries out, set mant=0x800000 and exp+1.
    - Overflow: exp>=255 gives ±inf (sign,0xFF,0).
    - Underflow: exp<=0 gives signed zero (FTZ on output).
    - Special cases override the arithmetic result:
      - NaN in either operand, or inf*zero, gives 0x7FC00000.
      - inf*finite nonzero or inf*inf gives ±inf.
      - zero*finite gives ±0.
    - Write result, drop busy, return to IDLE.
- Latency is fixed at 26 busy cycles regardless of operand class.
- Exceptions are not flagged; status is encoded in the result only.

Test Plan:
1. Reset-in-flight check: assert rst for 3 cycles, release, then start with a=0x3FC00000 (1.5), b=0x40000000 (2.0). Required: busy=0 and result=0 during reset; busy high for exactly 26 cycles; result=0x40400000 (3.0) on the busy-fall edge.
2. Signed product: a=0xC0200000 (-2.5), b=0x40800000 (4.0) gives 0xC1200000 (-10.0). Pulsing start mid-job with a=0x3F800000 is ignored: the result is unchanged and busy is not extended.
3. Rounding: a=b=0x3F800001 gives 0x3F800002. a=0x3FFFFFFF, b=0x3FFFFFFF gives 0x407FFFFE. Checked against a bit-accurate reference model with RNE and FTZ.
4. Overflow/underflow: 0x7F000000*0x7F000000 gives 0x7F800000. 0x00800000*0x00800000 gives 0x00000000. 0x80800000*0x00800000 gives 0x80000000.
5. Specials: 0x7F800000*0x00000000 gives 0x7FC00000. 0x7FC00001*0x3F800000 gives 0x7FC00000. 0xFF800000*0x40000000 gives 0xFF800000. 0x00000001*0x3F800000 gives 0x00000000 (FTZ).
6. Mid-job reset and throughput: start a job, assert rst at busy cycle 10, release, then keep start high with random operands for 1000 jobs. Required: no result write from the aborted job; exactly 27 cycles per job; all 1000 results match the model.
